// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for a handshaked data memory: alignment checks,
// byte-lane steering, pipeline stall and raw read-word return for load extension.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_sel,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [2:0]  rsp_load_sel,
    output logic [31:0] rsp_addr,
    output logic        adel,
    output logic        ades,
    output logic        timeout
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic [2:0]         rsp_load_sel_q, rsp_load_sel_d;
    logic [31:0]        rsp_addr_q, rsp_addr_d;
    logic [2:0]         sel_q, sel_d;
    logic               adel_q, adel_d;
    logic               ades_q, ades_d;
    logic               timeout_q, timeout_d;

    logic               is_half;
    logic               is_byte;
    logic               misaligned;

    function automatic logic [3:0] be_for(input logic we, input logic half, input logic byt,
                                          input logic [1:0] a);
        if (!we || (!half && !byt)) return 4'b1111;
        if (half)                   return a[1] ? 4'b1100 : 4'b0011;
        return 4'b0001 << a;
    endfunction

    function automatic logic [31:0] wdata_for(input logic half, input logic byt,
                                              input logic [31:0] w);
        if (half) return {2{w[15:0]}};
        if (byt)  return {4{w[7:0]}};
        return w;
    endfunction

    assign is_half    = (req_sel == 3'd1) || (req_sel == 3'd3) || (req_sel == 3'd5);
    assign is_byte    = (req_sel == 3'd2) || (req_sel == 3'd4);
    assign misaligned = is_half ? req_addr[0] : (is_byte ? 1'b0 : (req_addr[1:0] != 2'b00));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        we_d           = we_q;
        addr_d         = addr_q;
        be_d           = be_q;
        wdata_d        = wdata_q;
        sel_d          = sel_q;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_load_sel_d = rsp_load_sel_q;
        rsp_addr_d     = rsp_addr_q;
        adel_d         = 1'b0;
        ades_d         = 1'b0;
        timeout_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        state_d = ERR;
                        adel_d  = !req_we;
                        ades_d  = req_we;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        we_d    = req_we;
                        addr_d  = req_addr;
                        sel_d   = req_sel;
                        be_d    = be_for(req_we, is_half, is_byte, req_addr[1:0]);
                        wdata_d = wdata_for(is_half, is_byte, req_wdata);
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d = DONE;
                    if (!we_q) begin
                        rsp_valid_d    = 1'b1;
                        rsp_rdata_d    = mem_rdata;
                        rsp_load_sel_d = sel_q;
                        rsp_addr_d     = addr_q;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = ERR;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // DONE ignores the request inputs: the pipeline still shows the finished instruction.
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            be_q           <= '0;
            wdata_q        <= '0;
            sel_q          <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_load_sel_q <= '0;
            rsp_addr_q     <= '0;
            adel_q         <= 1'b0;
            ades_q         <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            be_q           <= be_d;
            wdata_q        <= wdata_d;
            sel_q          <= sel_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_load_sel_q <= rsp_load_sel_d;
            rsp_addr_q     <= rsp_addr_d;
            adel_q         <= adel_d;
            ades_q         <= ades_d;
            timeout_q      <= timeout_d;
        end
    end

    // Stall in IDLE is combinational so the request is frozen on the very cycle it appears.
    assign stall        = (state_q == BUSY) || ((state_q == IDLE) && req_valid && reset);
    assign mem_req      = (state_q == BUSY);
    assign mem_we       = mem_req && we_q;
    assign mem_addr     = {addr_q[31:2], 2'b00};
    assign mem_be       = be_q;
    assign mem_wdata    = wdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_load_sel = rsp_load_sel_q;
    assign rsp_addr     = rsp_addr_q;
    assign adel         = adel_q;
    assign ades         = ades_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected bus requests, load responses and
// error pulses are queued when a request is driven and consumed by a negedge monitor.
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_sel;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [2:0]  rsp_load_sel;
    logic [31:0] rsp_addr;
    logic        adel;
    logic        ades;
    logic        timeout;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_sel(req_sel),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_load_sel(rsp_load_sel), .rsp_addr(rsp_addr),
        .adel(adel), .ades(ades), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [2:0]  sel;
        logic [31:0] addr;
    } rsp_exp_t;

    mem_exp_t    mem_q[$];
    rsp_exp_t    rsp_q[$];
    logic [2:0]  err_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic        mem_req_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit m_half(input logic [2:0] sel);
        return (sel == 3'd1) || (sel == 3'd3) || (sel == 3'd5);
    endfunction

    function automatic bit m_byte(input logic [2:0] sel);
        return (sel == 3'd2) || (sel == 3'd4);
    endfunction

    function automatic bit m_mis(input logic [2:0] sel, input logic [31:0] a);
        if (m_byte(sel)) return 1'b0;
        if (m_half(sel)) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [2:0] sel, input logic [31:0] a);
        if (!we) return 4'b1111;
        if (m_half(sel)) return a[1] ? 4'b1100 : 4'b0011;
        if (m_byte(sel)) begin
            case (a[1:0])
                2'd0:    return 4'b0001;
                2'd1:    return 4'b0010;
                2'd2:    return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] sel, input logic [31:0] w);
        if (m_half(sel)) return {w[15:0], w[15:0]};
        if (m_byte(sel)) return {w[7:0], w[7:0], w[7:0], w[7:0]};
        return w;
    endfunction

    // Monitor: each new bus request, load response and error pulse consumes one expectation.
    always @(negedge clk) begin
        mem_exp_t me;
        rsp_exp_t re;
        logic [2:0] ee;
        if (mem_req && !mem_req_prev) begin
            if (mem_q.size() == 0) chk("mem_unexpected", 32'd1, 32'd0);
            else begin
                me = mem_q.pop_front();
                chk("mem_we",   {31'd0, mem_we}, {31'd0, me.we});
                chk("mem_addr", mem_addr, me.addr);
                chk("mem_be",   {28'd0, mem_be}, {28'd0, me.be});
                if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
            end
        end
        if (rsp_valid) begin
            if (rsp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
            else begin
                re = rsp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, re.rdata);
                chk("rsp_sel",   {29'd0, rsp_load_sel}, {29'd0, re.sel});
                chk("rsp_addr",  rsp_addr, re.addr);
            end
        end
        if (adel || ades || timeout) begin
            if (err_q.size() == 0) chk("err_unexpected", {29'd0, timeout, ades, adel}, 32'd0);
            else begin
                ee = err_q.pop_front();
                chk("err_kind", {29'd0, timeout, ades, adel}, {29'd0, ee});
            end
        end
        mem_req_prev <= mem_req;
    end

    // Called at posedge+1 with the controller in IDLE; ack_cyc=0 means the memory never answers.
    task automatic run_op(input string tag, input logic we, input logic [2:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ack_cyc, input logic hold);
        mem_exp_t me;
        rsp_exp_t re;
        bit mis;
        bit done;
        int stall_n;
        int req_n;
        int cyc;
        int exp_stall;
        int exp_req;
        mis       = m_mis(sel, addr);
        req_we    = we;
        req_sel   = sel;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        if (mis) begin
            err_q.push_back(we ? 3'b010 : 3'b001);
        end else begin
            me.we    = we;
            me.addr  = {addr[31:2], 2'b00};
            me.be    = m_be(we, sel, addr);
            me.wdata = m_wdata(sel, wdata);
            mem_q.push_back(me);
            if (ack_cyc == 0) err_q.push_back(3'b100);
            else if (!we) begin
                re.rdata = rdata;
                re.sel   = sel;
                re.addr  = addr;
                rsp_q.push_back(re);
            end
        end
        exp_stall = mis ? 1 : ((ack_cyc == 0) ? 1 + TIMEOUT : 1 + ack_cyc);
        exp_req   = mis ? 0 : ((ack_cyc == 0) ? TIMEOUT : ack_cyc);
        stall_n = 0;
        req_n   = 0;
        cyc     = 0;
        done    = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (mem_req) req_n++;
            if (stall) stall_n++;
            else if (stall_n > 0) done = 1'b1;
            mem_ack   = mem_req && (ack_cyc != 0) && (req_n == ack_cyc);
            mem_rdata = mem_ack ? rdata : $urandom;
        end
        if (!done) chk({tag, "_bound"}, 32'd0, 32'd1);
        chk({tag, "_stall_cycles"}, stall_n, exp_stall);
        chk({tag, "_req_cycles"},   req_n,   exp_req);
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        req_valid = hold;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_sel   = 3'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_stall",   {31'd0, stall},   32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_bus",     {mem_addr ^ mem_wdata}, 32'd0);
        chk("rst_be_we",   {27'd0, mem_we, mem_be}, 32'd0);
        chk("rst_rsp",     rsp_rdata | rsp_addr, 32'd0);
        chk("rst_pulses",  {27'd0, rsp_load_sel, rsp_valid, adel, ades, timeout} , 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op("lw",   1'b0, 3'd0, 32'h0000_0100, 32'h0,          32'hDEAD_BEEF, 1, 1'b0);
        run_op("sb",   1'b1, 3'd2, 32'h0000_0103, 32'h0000_00A5,  32'h0,         1, 1'b0);
        chk("rsp_hold", rsp_rdata, 32'hDEAD_BEEF);
        run_op("sh",   1'b1, 3'd1, 32'h0000_0102, 32'h0000_1234,  32'h0,         2, 1'b0);
        run_op("lh_mis", 1'b0, 3'd1, 32'h0000_0101, 32'h0,        32'h0,         1, 1'b0);
        run_op("sw_mis", 1'b1, 3'd0, 32'h0000_0106, 32'h5555_AAAA, 32'h0,        1, 1'b0);
        run_op("lw_slow", 1'b0, 3'd0, 32'h0000_0200, 32'h0,       32'hCAFE_F00D, 5, 1'b0);
        run_op("lw_tmo", 1'b0, 3'd0, 32'h0000_0204, 32'h0,        32'h0,         0, 1'b0);
        chk("tmo_rsp_hold", rsp_rdata, 32'hCAFE_F00D);

        // A stray ack while idle must not start anything.
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("idle_ack_req",   {31'd0, mem_req}, 32'd0);
        chk("idle_ack_stall", {31'd0, stall},   32'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;

        // Reset in the middle of an access.
        req_we    = 1'b0;
        req_sel   = 3'd0;
        req_addr  = 32'h0000_0300;
        req_valid = 1'b1;
        begin
            mem_exp_t me;
            me.we    = 1'b0;
            me.addr  = 32'h0000_0300;
            me.be    = 4'b1111;
            me.wdata = 32'h0;
            mem_q.push_back(me);
        end
        @(negedge clk);
        chk("mid_idle_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        chk("mid_busy_req", {31'd0, mem_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_req",   {31'd0, mem_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall},   32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_op("lbu", 1'b0, 3'd4, 32'h0000_0203, 32'h0, 32'h1122_3344, 2, 1'b0);
        chk("lbu_sel_hold",  {29'd0, rsp_load_sel}, 32'd4);
        chk("lbu_addr_hold", rsp_addr, 32'h0000_0203);

        // Back-to-back with req_valid held: DONE must not relaunch the load.
        run_op("b2b_lw", 1'b0, 3'd0, 32'h0000_0400, 32'h0,         32'h7777_8888, 1, 1'b1);
        run_op("b2b_sw", 1'b1, 3'd0, 32'h0000_0404, 32'h9ABC_DEF0, 32'h0,         1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic        rw;
            logic [2:0]  rs;
            logic [31:0] ra;
            rw = 1'($urandom_range(0, 1));
            rs = 3'($urandom_range(0, 7));
            ra = $urandom;
            run_op("rnd", rw, rs, ra, $urandom, $urandom, $urandom_range(1, 4), 1'b0);
        end

        repeat (2) @(negedge clk);
        chk("mem_q_left", mem_q.size(), 32'd0);
        chk("rsp_q_left", rsp_q.size(), 32'd0);
        chk("err_q_left", err_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
